// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter stage of the single-cycle CPU.
//
// The block holds the PC and feeds the external branch-target adder:
//   operand A = PC + 4
//   operand B = sign-extended immediate << 2
// It loads the adder result on a taken branch. Before loading, it waits
// BRANCH_WAIT cycles so the adder output can settle. It also handles J-type
// jumps, stalls, halt, and misaligned redirect targets.
//
// Ports
//   clock_in             system clock, all state on rising edge
//   reset_in             synchronous active-high reset
//   stall_in             freeze PC / FSM this cycle
//   halt_in              enter HALT (left only by reset)
//   branch_in            conditional branch in flight
//   bne_in               branch sense (0: take on zero, 1: take on !zero)
//   zero_in              ALU zero flag
//   jump_in              J instruction in flight
//   jump_index_in[25:0]  J-format target index
//   imm_in[15:0]         I-format immediate
//   branch_target_in     adder result (pc_plus4_out + offset_out)
//   pc_out               current PC
//   pc_plus4_out         adder operand A
//   offset_out           adder operand B
//   busy_out             high while waiting for the adder
//   misalign_out         sticky: a misaligned redirect target was seen
//   retired_count_out    completed PC updates, wraps at 2^32
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BRANCH_WAIT = 1,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0080
) (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic        stall_in,
    input  logic        halt_in,
    input  logic        branch_in,
    input  logic        bne_in,
    input  logic        zero_in,
    input  logic        jump_in,
    input  logic [25:0] jump_index_in,
    input  logic [15:0] imm_in,
    input  logic [31:0] branch_target_in,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic [31:0] offset_out,
    output logic        busy_out,
    output logic        misalign_out,
    output logic [31:0] retired_count_out
);

    typedef enum logic [1:0] {S_RUN, S_BR_WAIT, S_HALT} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(BRANCH_WAIT);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] pc_q;
    logic        busy_q;
    logic        misalign_q;
    logic [31:0] retired_q;

    logic        taken;
    logic        br_misaligned;
    logic [31:0] br_next_pc;
    logic [31:0] jump_target;

    assign pc_plus4_out = pc_q + 32'd4;
    assign offset_out   = {{14{imm_in[15]}}, imm_in, 2'b00};
    assign taken        = branch_in & (zero_in ^ bne_in);

    // A J target is built with two zero low bits, so it can never be
    // misaligned. Only the adder result needs the alignment check.
    assign jump_target   = {pc_plus4_out[31:28], jump_index_in, 2'b00};
    assign br_misaligned = |branch_target_in[1:0];
    assign br_next_pc    = br_misaligned ? EXC_VECTOR : branch_target_in;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q    <= S_RUN;
            cnt_q      <= 4'd0;
            pc_q       <= RESET_PC;
            busy_q     <= 1'b0;
            misalign_q <= 1'b0;
            retired_q  <= 32'd0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (!stall_in) begin
                        if (halt_in) begin
                            state_q <= S_HALT;
                        end else if (jump_in) begin
                            pc_q      <= jump_target;
                            retired_q <= retired_q + 32'd1;
                        end else if (taken) begin
                            if (BRANCH_WAIT == 0) begin
                                pc_q       <= br_next_pc;
                                misalign_q <= misalign_q | br_misaligned;
                                retired_q  <= retired_q + 32'd1;
                            end else begin
                                state_q <= S_BR_WAIT;
                                cnt_q   <= WAIT_INIT;
                                busy_q  <= 1'b1;
                            end
                        end else begin
                            pc_q      <= pc_plus4_out;
                            retired_q <= retired_q + 32'd1;
                        end
                    end
                end
                S_BR_WAIT: begin
                    // Branch, jump and halt are deliberately ignored here.
                    // The adder result is sampled on the final edge only.
                    if (!stall_in) begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            pc_q       <= br_next_pc;
                            misalign_q <= misalign_q | br_misaligned;
                            retired_q  <= retired_q + 32'd1;
                            state_q    <= S_RUN;
                            busy_q     <= 1'b0;
                        end
                    end
                end
                default: ; // S_HALT: everything frozen until reset
            endcase
        end
    end

    assign pc_out            = pc_q;
    assign busy_out          = busy_q;
    assign misalign_out      = misalign_q;
    assign retired_count_out = retired_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage of the single-cycle CPU.
- Holds the PC and drives the two operands of the branch-target adder: PC+4 and the sign-extended immediate shifted left by 2.
- Consumes the adder's 32-bit result to redirect fetch on taken branches.
- Waits a programmable number of cycles for the adder result to settle before loading it, and handles jumps, stalls, halt, and misaligned targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BRANCH_WAIT, 1, cycles to wait for branch_target_in to settle before loading it (0..15; 0 = load in the same cycle).
- EXC_VECTOR, 32'h0000_0080, PC loaded when a redirect target is misaligned.

Ports:
- clock_in, input, 1, system clock; all state updates on rising edge.
- reset_in, input, 1, synchronous active-high reset.
- stall_in, input, 1, freeze PC and FSM progress this cycle.
- halt_in, input, 1, enter HALT.
- branch_in, input, 1, current instruction is a conditional branch.
- bne_in, input, 1, branch sense: 0 = take when zero_in=1; 1 = take when zero_in=0.
- zero_in, input, 1, ALU zero flag.
- jump_in, input, 1, current instruction is J.
- jump_index_in, input, 26, J-format target index.
- imm_in, input, 16, I-format immediate.
- branch_target_in, input, 32, branch-target adder result.
- pc_out, output, 32, current PC.
- pc_plus4_out, output, 32, pc_out+4, wrapping modulo 2^32; drives adder operand A.
- offset_out, output, 32, {{14{imm_in[15]}}, imm_in, 2'b00}; drives adder operand B.
- busy_out, output, 1, high while in BR_WAIT.
- misalign_out, output, 1, sticky flag: a misaligned target was seen.
- retired_count_out, output, 32, count of completed PC updates.

Behaviour:
- Reset (synchronous, from any state, including mid-BR_WAIT):
  - pc_out=RESET_PC, state=RUN, wait counter=0.
  - busy_out=0, misalign_out=0, retired_count_out=0.
- Combinational outputs: pc_plus4_out and offset_out are purely combinational from pc_out and imm_in.
- States: RUN, BR_WAIT, HALT.
- RUN, stall_in=1: all state holds.
- RUN, stall_in=0: priority is halt_in > jump_in > taken branch > sequential.
  - halt_in: go to HALT; PC holds; no retire.
  - jump_in: target = {pc_plus4_out[31:28], jump_index_in, 2'b00}. Load it; retire. Jump wins over a simultaneous branch.
  - Taken branch (branch_in & (zero_in ^ bne_in)):
    - BRANCH_WAIT=0: load branch_target_in this edge; retire.
    - Otherwise: go to BR_WAIT, counter=BRANCH_WAIT, PC holds, busy_out=1 from the next cycle.
  - Otherwise: pc_out <= pc_plus4_out; retire.
- BR_WAIT:
  - branch_in, jump_in and halt_in are ignored.
  - stall_in=1 freezes the counter.
  - Otherwise the counter decrements each cycle.
  - On the edge where the counter equals 1: load branch_target_in as sampled on that edge, retire, return to RUN; busy_out falls in the next cycle.
  - Total latency from branch accept to new PC: BRANCH_WAIT cycles.
- HALT: PC, counter and count frozen; the only exit is reset.
- Misalignment: any redirect target (jump or branch) with bits [1:0]≠0 loads EXC_VECTOR instead, sets misalign_out (sticky until reset), and still counts as a retire. A J target is always aligned.
- retired_count_out: +1 per retire; wraps from 32'hFFFF_FFFF to 0.
- PC wrap: sequential advance from 32'hFFFF_FFFC goes to 32'h0000_0000, no flag.

Test Plan:
- Reset and sequential fetch: reset high for 2 cycles, then 4 idle cycles → pc_out 0x0, 0x4, 0x8, 0xC, 0x10; retired_count_out=4; pc_plus4_out=0x14.
- Taken branch with BRANCH_WAIT=1: pc=0x10, imm_in=16'hFFFC, branch_in=1, zero_in=1, bne_in=0.
  - Required: offset_out=0xFFFF_FFF0; adder model returns 0x04.
  - busy_out=1 for one cycle, then pc_out=0x04.
  - Repeat with bne_in=1 → not taken, pc=0x14.
- BRANCH_WAIT=3 with stall: stall_in=1 on the second wait cycle → busy_out stays high for 4 cycles, then the PC loads the target; branch_in pulses during wait are ignored.
- Jump vs branch collision: pc=0x3000_0000, jump_in=1, jump_index_in=26'h0000100, taken branch asserted in the same cycle → pc_out=0x3000_0400.
- Misaligned branch: branch_target_in=0x0000_0102 → pc_out=0x80, misalign_out=1 and stays 1 through later branches until reset.
- Boundaries:
  - pc=0xFFFF_FFFC sequential → 0x0.
  - Count preloaded to 0xFFFF_FFFF via forced retires → wraps to 0.
  - reset_in in the middle of BR_WAIT → RUN, pc=RESET_PC, busy_out=0 next cycle.
  - halt_in → pc frozen for 10 cycles until reset.
